// File: rtl/uart_pkg.sv
// Shared UART types, frame constants and baud divisor helper.
// No timing of its own; nothing here carries flow control.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input with selectable reset value.
// Latency 2 cycles; no backpressure (free-running sampler).
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RST_VAL = IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: byte-wide host side, serial pins on the other.
// TX occupies 10 bit times per byte and ignores tx_start while busy; RX has no backpressure.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]        tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_q, tx_d;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == CNT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    tx_d       = IDLE_LEVEL;

    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_shreg_d = tx_data;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx_q == IDX_LAST) tx_state_d = TX_STOP;
          else                      tx_idx_d   = tx_idx_q + 1'b1;
        end
      end
      TX_STOP: begin
        // A request held through the final stop cycle chains the next frame with no idle gap.
        if (tx_bit_end) begin
          if (tx_start) begin
            tx_shreg_d = tx_data;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Pin is registered from the next state so it never glitches on state decode.
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shreg_d[tx_idx_d];
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      tx_q       <= IDLE_LEVEL;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      tx_q       <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign tx_done = (tx_state_q == TX_STOP) && tx_bit_end;

  // ---------------- receiver ----------------
  logic                 rx_s;
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [IW-1:0]        rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic                 rx_stop_wait_q, rx_stop_wait_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_ferr;
  logic                 rx_bit_end;

  uart_sync2 #(.RST_VAL(IDLE_LEVEL)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign rx_bit_end = (rx_cnt_q == CNT_LAST);

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_idx_d       = rx_idx_q;
    rx_shreg_d     = rx_shreg_q;
    rx_stop_wait_d = rx_stop_wait_q;
    rx_data_d      = rx_data_q;
    rx_done_d      = 1'b0;
    rx_ferr        = 1'b0;

    if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_IDLE) begin
      rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_shreg_d = {rx_s, rx_shreg_q[DATA_BITS-1:1]};
          if (rx_idx_q == IDX_LAST) begin
            rx_stop_wait_d = 1'b0;
            rx_state_d     = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (!rx_stop_wait_q) begin
          if (rx_bit_end) begin
            if (rx_s) begin
              rx_stop_wait_d = 1'b1;
            end else begin
              rx_ferr    = 1'b1;
              rx_state_d = RX_WAIT_IDLE;
            end
          end
        end else if (rx_cnt_q == CNT_HALF) begin
          rx_data_d      = rx_shreg_q;
          rx_done_d      = 1'b1;
          rx_stop_wait_d = 1'b0;
          rx_cnt_d       = '0;
          // Take the idle-line look in this same cycle so a chained start bit keeps its alignment.
          rx_state_d     = rx_s ? RX_IDLE : RX_START;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_idx_q       <= '0;
      rx_shreg_q     <= '0;
      rx_stop_wait_q <= 1'b0;
      rx_data_q      <= '0;
      rx_done_q      <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_idx_q       <= rx_idx_d;
      rx_shreg_q     <= rx_shreg_d;
      rx_stop_wait_q <= rx_stop_wait_d;
      rx_data_q      <= rx_data_d;
      rx_done_q      <= rx_done_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_done      = rx_done_q;
  assign rx_frame_err = rx_ferr;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: loopback frames, back-to-back, glitch, framing error, reset abort.
module tb_uart_transceiver;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;

  logic       loopback;
  logic       rx_drv;
  logic [7:0] last_rx;
  int         cyc;
  int         n_checks;
  int         n_errors;

  int         txd_q[$];
  int         rxd_cyc[$];
  logic [7:0] rxd_dat[$];
  int         ferr_q[$];

  assign rx = loopback ? tx : rx_drv;

  uart_transceiver #(
    .CLK_FREQ     (100_000_000),
    .BAUD_RATE    (115200),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_frame_err (rx_frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_done) txd_q.push_back(cyc);
      if (rx_done) begin
        rxd_cyc.push_back(cyc);
        rxd_dat.push_back(rx_data);
      end
      if (rx_frame_err) ferr_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clear_events();
    txd_q.delete();
    rxd_cyc.delete();
    rxd_dat.delete();
    ferr_q.delete();
  endtask

  // Send one byte over the loopback and check line waveform, tx timing and received byte.
  task automatic send_byte(input logic [7:0] b, input bit intrude, input string tag);
    int         c0;
    int         lat;
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    clear_events();
    loopback = 1'b1;
    @(negedge clk);
    c0 = cyc;
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wait_until(c0 + 1 + k * CPB + CPB / 2);
      check_eq($sformatf("%s_bit%0d", tag, k), tx, frame[k]);
      if (k == 4) begin
        check_eq({tag, "_busy"}, tx_busy, 1);
        if (intrude) begin
          tx_data  = 8'h12;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
        end
      end
    end
    wait_until(c0 + 11 * CPB - 4);
    check_eq({tag, "_txdone_cnt"}, txd_q.size(), 1);
    check_eq({tag, "_txdone_at"}, (txd_q.size() > 0) ? txd_q[0] - c0 : -1, 10 * CPB);
    check_eq({tag, "_rxdone_cnt"}, rxd_cyc.size(), 1);
    lat = (rxd_cyc.size() > 0 && txd_q.size() > 0) ? rxd_cyc[0] - txd_q[0] : -1;
    check_eq({tag, "_rx_lat_2to4"}, (lat >= 2 && lat <= 4), 1);
    last_rx = b;
    check_eq({tag, "_rx_data"}, rx_data, last_rx);
    check_eq({tag, "_ferr_cnt"}, ferr_q.size(), 0);
    check_eq({tag, "_idle_busy"}, tx_busy, 0);
    check_eq({tag, "_idle_tx"}, tx, 1);
  endtask

  // Drive a frame on rx directly; stop_bit lets the bench forge a framing error.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    loopback = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rx_drv = frame[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int c0;
    int td;
    int guard;
    int lat;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    loopback = 1'b1;
    rx_drv   = 1'b1;
    last_rx  = 8'h00;

    repeat (2) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_tx", tx, 1);
    check_eq("post_rst_busy", tx_busy, 0);
    check_eq("post_rst_pulses", {tx_done, rx_done, rx_frame_err}, 3'b000);
    check_eq("post_rst_rx_data", rx_data, 8'h00);

    send_byte(8'hAA, 1'b0, "aa");
    send_byte(8'h55, 1'b1, "busy_ign");

    // Back-to-back: keep tx_start high and swap the payload in the tx_done cycle.
    clear_events();
    loopback = 1'b1;
    @(negedge clk);
    c0 = cyc;
    tx_data  = 8'h00;
    tx_start = 1'b1;
    guard = 0;
    while (!tx_done && guard < 20 * CPB) begin
      @(negedge clk);
      guard++;
    end
    check_eq("b2b_txdone_seen", tx_done, 1);
    td = cyc;
    check_eq("b2b_txdone_at", td - c0, 10 * CPB);
    tx_data = 8'hFF;
    @(negedge clk);
    tx_start = 1'b0;
    check_eq("b2b_no_gap_tx", tx, 0);
    check_eq("b2b_no_gap_busy", tx_busy, 1);
    wait_until(c0 + 21 * CPB);
    check_eq("b2b_txdone_cnt", txd_q.size(), 2);
    check_eq("b2b_period", (txd_q.size() > 1) ? txd_q[1] - txd_q[0] : -1, 10 * CPB);
    check_eq("b2b_rxdone_cnt", rxd_cyc.size(), 2);
    check_eq("b2b_rx0", (rxd_dat.size() > 0) ? rxd_dat[0] : 8'hxx, 8'h00);
    check_eq("b2b_rx1", (rxd_dat.size() > 1) ? rxd_dat[1] : 8'hxx, 8'hFF);
    lat = (rxd_cyc.size() > 1 && txd_q.size() > 1) ? rxd_cyc[1] - txd_q[1] : -1;
    check_eq("b2b_rx1_lat_2to4", (lat >= 2 && lat <= 4), 1);
    check_eq("b2b_ferr_cnt", ferr_q.size(), 0);
    last_rx = 8'hFF;

    // Glitch shorter than half a bit must be rejected silently.
    clear_events();
    loopback = 1'b0;
    rx_drv   = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_eq("glitch_rxdone", rxd_cyc.size(), 0);
    check_eq("glitch_ferr", ferr_q.size(), 0);

    drive_frame(8'h3C, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check_eq("ferr_cnt", ferr_q.size(), 1);
    check_eq("ferr_no_rxdone", rxd_cyc.size(), 0);
    check_eq("ferr_rx_data_kept", rx_data, last_rx);

    clear_events();
    drive_frame(8'h5A, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check_eq("rearm_rxdone_cnt", rxd_cyc.size(), 1);
    last_rx = 8'h5A;
    check_eq("rearm_rx_data", rx_data, last_rx);
    check_eq("rearm_ferr", ferr_q.size(), 0);

    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // Reset while DATA is driving a zero bit.
    clear_events();
    loopback = 1'b1;
    @(negedge clk);
    c0 = cyc;
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_until(c0 + 1 + 3 * CPB + CPB / 2);
    check_eq("midrst_pre_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tx", tx, 1);
    check_eq("midrst_busy", tx_busy, 0);
    last_rx = 8'h00;
    check_eq("midrst_rx_data", rx_data, last_rx);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'hC3, 1'b0, "post_midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
